// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
// Holds the FSM state enum, the saturating adder and the refractory counter sizing.
package lif_pkg;

    typedef enum logic [0:0] {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } lif_state_e;

    // Counter must hold the value REFRAC; never narrower than one bit so REFRAC=0 still elaborates.
    function automatic int refrac_cnt_width(input int refrac);
        int w;
        w = $clog2(refrac + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int REFRAC_DEFAULT   = 2;
    localparam int REFRAC_CNT_W_DEF = refrac_cnt_width(REFRAC_DEFAULT);

    // Unsigned a + b clamped to 2^width-1; width must be 31 or less.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << width) - 33'd1;
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_membrane_integrator_leak_sat.sv
// Combinational datapath: leak the membrane, add the input with saturation,
// and compare the result against the firing threshold.
module lif_leak_sat
    import lif_pkg::*;
#(
    parameter int W_IN       = 12,
    parameter int W_V        = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [W_V-1:0]  i_v,
    input  logic [W_IN-1:0] i_sum,
    input  logic [W_V-1:0]  i_threshold,
    output logic [W_V-1:0]  o_v_next,
    output logic            o_fire
);

    logic [W_V-1:0] w_leak;
    logic [W_V-1:0] w_v_leaked;

    // A shift of zero would drain the whole potential, so it means "no leak" instead.
    generate
        if (LEAK_SHIFT == 0) begin : g_no_leak
            assign w_leak = '0;
        end else begin : g_leak
            assign w_leak = i_v >> LEAK_SHIFT;
        end
    endgenerate

    assign w_v_leaked = i_v - w_leak;
    assign o_v_next   = W_V'(sat_add(32'(w_v_leaked), 32'(i_sum), W_V));
    assign o_fire     = (o_v_next >= i_threshold);

endmodule

// File: rtl/lif_membrane_integrator.sv
// One leaky integrate-and-fire neuron with valid/ready on both sides and a
// single registered output stage (one-cycle latency, full throughput).
module lif_membrane_integrator
    import lif_pkg::*;
#(
    parameter int W_IN       = 12,
    parameter int W_V        = 16,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W_IN-1:0] in_sum,
    input  logic [W_V-1:0]  threshold,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_spike,
    output logic [W_V-1:0]  out_v
);

    localparam int CW = refrac_cnt_width(REFRAC);

    lif_state_e     r_state;
    lif_state_e     w_state_next;
    logic [W_V-1:0] r_v;
    logic [W_V-1:0] w_v_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;
    logic           r_out_valid;
    logic           w_out_valid_next;
    logic           r_out_spike;
    logic           w_out_spike_next;
    logic [W_V-1:0] r_out_v;
    logic [W_V-1:0] w_out_v_next;

    logic           w_accept;
    logic [W_V-1:0] w_int_v;
    logic           w_fire;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_spike = r_out_spike;
    assign out_v     = r_out_v;

    lif_leak_sat #(
        .W_IN       (W_IN),
        .W_V        (W_V),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_leak_sat (
        .i_v         (r_v),
        .i_sum       (in_sum),
        .i_threshold (threshold),
        .o_v_next    (w_int_v),
        .o_fire      (w_fire)
    );

    always_comb begin
        w_state_next     = r_state;
        w_v_next         = r_v;
        w_cnt_next       = r_cnt;
        w_out_valid_next = r_out_valid;
        w_out_spike_next = r_out_spike;
        w_out_v_next     = r_out_v;
        if (w_accept) begin
            w_out_valid_next = 1'b1;
            case (r_state)
                INTEGRATE: begin
                    w_out_v_next     = w_int_v;
                    w_out_spike_next = w_fire;
                    if (w_fire) begin
                        w_v_next = '0;
                        if (REFRAC > 0) begin
                            w_cnt_next   = CW'(REFRAC);
                            w_state_next = REFRACTORY;
                        end
                    end else begin
                        w_v_next = w_int_v;
                    end
                end
                REFRACTORY: begin
                    // Input is discarded; the timestep still produces a (silent) result.
                    w_out_v_next     = '0;
                    w_out_spike_next = 1'b0;
                    w_v_next         = '0;
                    w_cnt_next       = r_cnt - CW'(1);
                    if (r_cnt <= CW'(1)) begin
                        w_state_next = INTEGRATE;
                    end
                end
                default: w_state_next = INTEGRATE;
            endcase
        end else if (r_out_valid && out_ready) begin
            w_out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INTEGRATE;
            r_v         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_spike <= 1'b0;
            r_out_v     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_v         <= w_v_next;
            r_cnt       <= w_cnt_next;
            r_out_valid <= w_out_valid_next;
            r_out_spike <= w_out_spike_next;
            r_out_v     <= w_out_v_next;
        end
    end

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Directed bench for lif_membrane_integrator: a default-parameter neuron and a
// no-leak neuron used for the saturation corner.
module tb_lif_membrane_integrator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default parameters (LEAK_SHIFT=3, REFRAC=2)
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [11:0] a_in_sum = '0;
    logic [15:0] a_thr = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic        a_out_spike;
    logic [15:0] a_out_v;

    // Instance B: leak disabled
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [11:0] b_in_sum = '0;
    logic [15:0] b_thr = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic        b_out_spike;
    logic [15:0] b_out_v;

    lif_membrane_integrator #(
        .W_IN(12), .W_V(16), .LEAK_SHIFT(3), .REFRAC(2)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sum    (a_in_sum),
        .threshold (a_thr),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_spike (a_out_spike),
        .out_v     (a_out_v)
    );

    lif_membrane_integrator #(
        .W_IN(12), .W_V(16), .LEAK_SHIFT(0), .REFRAC(2)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sum    (b_in_sum),
        .threshold (b_thr),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_spike (b_out_spike),
        .out_v     (b_out_v)
    );

    typedef struct {
        logic [11:0] sum;
        logic [15:0] thr;
        logic [15:0] exp_v;
        logic        exp_spike;
    } vec_t;

    vec_t tbl[6];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one input to A, let one edge pass, leave inputs asserted.
    task automatic step_a(input logic [11:0] s, input logic [15:0] t);
        a_in_valid = 1'b1;
        a_in_sum   = s;
        a_thr      = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bexp;
        // Leak 3: 0+100=100; 100-12+100=188; 188-23+100=265 fires; then two refractory steps; then 50.
        tbl[0] = '{12'd100, 16'd200, 16'd100, 1'b0};
        tbl[1] = '{12'd100, 16'd200, 16'd188, 1'b0};
        tbl[2] = '{12'd100, 16'd200, 16'd265, 1'b1};
        tbl[3] = '{12'd500, 16'd200, 16'd0,   1'b0};
        tbl[4] = '{12'd500, 16'd200, 16'd0,   1'b0};
        tbl[5] = '{12'd50,  16'd200, 16'd50,  1'b0};

        do_reset();
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_spike", 32'(a_out_spike), 32'd0);
        chk("rst_out_v",     32'(a_out_v),     32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);

        // Cases 1 and 2: continuous flow through integrate, fire, refractory.
        for (int i = 0; i < 6; i++) begin
            step_a(tbl[i].sum, tbl[i].thr);
            chk($sformatf("t12_valid[%0d]", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("t12_v[%0d]", i),     32'(a_out_v),     32'(tbl[i].exp_v));
            chk($sformatf("t12_spike[%0d]", i), 32'(a_out_spike), 32'(tbl[i].exp_spike));
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("consume_no_accept_valid", 32'(a_out_valid), 32'd0);

        // Case 3: no leak, 4095 per step, saturation at the 17th step.
        b_thr      = 16'hFFFF;
        b_in_sum   = 12'd4095;
        b_in_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            bexp = (k == 17) ? 16'hFFFF : 16'(4095 * k);
            chk($sformatf("t3_v[%0d]", k),     32'(b_out_v),     32'(bexp));
            chk($sformatf("t3_spike[%0d]", k), 32'(b_out_spike), (k == 17) ? 32'd1 : 32'd0);
        end
        b_in_valid = 1'b0;

        // Case 4: backpressure with continuous in_valid.
        do_reset();
        a_out_ready = 1'b0;
        step_a(12'd10, 16'd1000);
        chk("t4_first_v", 32'(a_out_v), 32'd10);
        a_in_sum = 12'd20;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_stall_ready[%0d]", c), 32'(a_in_ready),  32'd0);
            chk($sformatf("t4_stall_valid[%0d]", c), 32'(a_out_valid), 32'd1);
            chk($sformatf("t4_stall_v[%0d]", c),     32'(a_out_v),     32'd10);
            chk($sformatf("t4_stall_spk[%0d]", c),   32'(a_out_spike), 32'd0);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        // 10-1+20=29; 29-3+30=56; 56-7+40=89
        step_a(12'd20, 16'd1000);
        chk("t4_rel_v0", 32'(a_out_v), 32'd29);
        step_a(12'd30, 16'd1000);
        chk("t4_rel_v1", 32'(a_out_v), 32'd56);
        step_a(12'd40, 16'd1000);
        chk("t4_rel_v2", 32'(a_out_v), 32'd89);
        chk("t4_rel_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t4_drain_valid", 32'(a_out_valid), 32'd0);

        // Case 5: reset while refractory with a result held under backpressure.
        do_reset();
        a_out_ready = 1'b0;
        step_a(12'd300, 16'd200);
        a_in_valid = 1'b0;
        chk("t5_fire_spike", 32'(a_out_spike), 32'd1);
        chk("t5_fire_v",     32'(a_out_v),     32'd300);
        a_in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        a_in_valid = 1'b0;
        chk("t5_rst_valid", 32'(a_out_valid), 32'd0);
        chk("t5_rst_ready", 32'(a_in_ready),  32'd1);
        a_out_ready = 1'b1;
        step_a(12'd30, 16'd200);
        a_in_valid = 1'b0;
        chk("t5_after_v",     32'(a_out_v),     32'd30);
        chk("t5_after_spike", 32'(a_out_spike), 32'd0);

        // Case 6: zero threshold fires on a zero sum and enters refractory.
        do_reset();
        step_a(12'd0, 16'd0);
        chk("t6_spike", 32'(a_out_spike), 32'd1);
        chk("t6_v",     32'(a_out_v),     32'd0);
        step_a(12'd100, 16'd0);
        a_in_valid = 1'b0;
        chk("t6_refrac_spike", 32'(a_out_spike), 32'd0);
        chk("t6_refrac_v",     32'(a_out_v),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lif_membrane_integrator.md
Name: lif_membrane_integrator

Overview:
Downstream consumer of the synaptic adder tree's per-timestep weighted-sum output; implements one leaky integrate-and-fire neuron.
- Each accepted sum: leaks the membrane potential, adds the sum with saturation, compares against a threshold, emits a spike and enters refractory on crossing.
- Valid/ready on both sides; registered output, one-cycle latency; feeds the spike router / output spike FIFO.

Parameters:
W_IN, 12, width of unsigned input sum (matches tree output W+D, e.g. W=8,N=16)
W_V, 16, width of unsigned membrane potential register
LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per timestep; 0 disables leak
REFRAC, 2, number of accepted timesteps discarded after a spike (0 = no refractory)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  in_sum valid for one timestep
in_ready  output  1  block can accept in_sum this cycle
in_sum  input  W_IN  unsigned weighted synaptic sum (zero-extended to W_V internally; W_IN <= W_V required)
threshold  input  W_V  firing threshold, sampled on the accept cycle
out_valid  output  1  result registered and pending
out_ready  input  1  downstream accepts result
out_spike  output  1  1 = neuron fired this timestep
out_v  output  W_V  membrane value after integration, before spike reset

Behaviour:
- Accept = in_valid && in_ready. Output consume = out_valid && out_ready.
- in_ready = !out_valid || out_ready. Single output register, no bubble under continuous flow.
- Reset: v=0, state=INTEGRATE, refrac_cnt=0, out_valid=0, out_spike=0, out_v=0.
- States: INTEGRATE, REFRACTORY.
- INTEGRATE, on accept:
  - leak = (LEAK_SHIFT==0) ? 0 : v >> LEAK_SHIFT
  - v_next = min(v - leak + in_sum, 2^W_V-1), computed at W_V+1 bits, then saturated.
  - out_v <= v_next. out_valid <= 1.
  - If v_next >= threshold: out_spike <= 1; v <= 0; if REFRAC>0, refrac_cnt <= REFRAC and go REFRACTORY.
  - Otherwise out_spike <= 0; v <= v_next.
- REFRACTORY, on accept:
  - Input discarded; v held at 0; out_v <= 0; out_spike <= 0; out_valid <= 1.
  - refrac_cnt decrements. When it reaches 0, go INTEGRATE. The next accept integrates normally.
- Latency: result visible the cycle after accept. State, v and counter change only on accept.
- Backpressure: out_valid && !out_ready holds out_* stable; in_ready=0; no state change.
- Simultaneous consume and accept in the same cycle: the new result replaces the old; out_valid stays 1.
- Consume without accept: out_valid <= 0.
- threshold == 0: every INTEGRATE accept spikes, including in_sum=0.
- Saturated v_next = 2^W_V-1 with threshold = 2^W_V-1: spikes.
- reset asserted mid-refractory or mid-backpressure: the pending result is dropped and all state is cleared. Reset dominates concurrent handshakes.

Decomposition:
- Package lif_pkg holds:
  - state enum lif_state_e {INTEGRATE, REFRACTORY}
  - function sat_add(a, b, width)
  - constant for the refractory counter width, $clog2(REFRAC+1) with a minimum of 1.
- Sub-module lif_leak_sat: combinational leak + saturating add + threshold compare. It is unit-tested separately.
- The top holds the handshake, FSM, counter and registers.

Test Plan:
1. Defaults, threshold=200, out_ready=1, in_sum=100 three times -> out_v=100,188,265; out_spike=0,0,1. v=0 after the third.
2. Continue case 1 with in_sum=500 twice, then 50 -> the two 500s give out_v=0, out_spike=0 (refractory). The 50 gives out_v=50, out_spike=0.
3. LEAK_SHIFT=0, threshold=0xFFFF, in_sum=4095 x17 -> out_v=4095..65520 without spikes. The 17th gives out_v=65535 (saturated), out_spike=1.
4. out_ready=0 for 5 cycles after the first result, in_valid=1 continuously -> in_ready=0, out_v/out_spike stable, v unchanged. Release -> one result per cycle, none lost or duplicated.
5. reset pulsed while in REFRACTORY with out_valid=1 -> next cycle out_valid=0, in_ready=1. in_sum=30, threshold=200 -> out_v=30, out_spike=0.
6. threshold=0, in_sum=0 -> out_spike=1, out_v=0, REFRACTORY entered.
